// File: rtl/proc_cell_n_if.sv
// Valid/ready bundle for proc_cell_n: NUM_IN join channels, mode select,
// one result channel and status. The cell takes the slave view.
interface proc_cell_n_if #(
  parameter int WIDTH     = 4,
  parameter int NUM_IN    = 4,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [1:0]              mode;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic [CNT_WIDTH-1:0]    result_count;

  modport master (
    output in_data, in_valid, mode, out_ready,
    input  in_ready, out_data, out_valid, busy, result_count
  );

  modport slave (
    input  in_data, in_valid, mode, out_ready,
    output in_ready, out_data, out_valid, busy, result_count
  );
endinterface

// File: rtl/proc_cell_n.sv
// Join-and-compute cell: collects one token per input channel in any order,
// combines them (wrap sum / saturating sum / max / xor) and emits one result.
module proc_cell_n #(
  parameter int WIDTH     = 4,
  parameter int NUM_IN    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  proc_cell_n_if.slave bus
);

  localparam int                SUM_W    = WIDTH + $clog2(NUM_IN);
  localparam logic [NUM_IN-1:0] ALL_ONES = '1;
  localparam logic [SUM_W-1:0]  SAT_MAX  = {{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_IN-1:0]    captured_q, captured_d;
  logic [NUM_IN-1:0]    take;
  logic [WIDTH-1:0]     operand_q [NUM_IN];
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [SUM_W-1:0]     sum_wide;
  logic [WIDTH-1:0]     max_val;
  logic [WIDTH-1:0]     xor_val;
  logic [WIDTH-1:0]     result;

  // Ready depends only on registered state, never on in_valid.
  assign bus.in_ready     = (state_q == COLLECT) ? ~captured_q : '0;
  assign take             = bus.in_valid & bus.in_ready;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.result_count = count_q;
  assign bus.busy         = (state_q != COLLECT) || (captured_q != '0);

  // Operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand array is reset so an aborted round can never leak
      // old operands into a later result.
      for (int i = 0; i < NUM_IN; i++) begin
        operand_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (take[i]) begin
          operand_q[i] <= bus.in_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Datapath: all four candidate results, then select by mode.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sum_wide = '0;
    max_val  = '0;
    xor_val  = '0;
    result   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum_wide = sum_wide + SUM_W'(operand_q[i]);
      if (operand_q[i] > max_val) begin
        max_val = operand_q[i];
      end
      xor_val = xor_val ^ operand_q[i];
    end
    case (bus.mode)
      2'b00: result = sum_wide[WIDTH-1:0];
      2'b01: result = (sum_wide > SAT_MAX) ? SAT_MAX[WIDTH-1:0] : sum_wide[WIDTH-1:0];
      2'b10: result = max_val;
      2'b11: result = xor_val;
      default: result = '0;
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    case (state_q)
      COLLECT: begin
        captured_d = captured_q | take;
        if (captured_d == ALL_ONES) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        out_data_d  = result;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        // out_data is deliberately left holding the last result.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          captured_d  = '0;
          count_d     = count_q + CNT_WIDTH'(1);
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d    = COLLECT;
        captured_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      captured_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      captured_q  <= captured_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

endmodule
